mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences and shares the single memory port. During boot, the host loader owns memory and the core is held idle. After the host signals completion, the port passes through a quiet settle window. The block then releases the core and arbitrates between the core fetcher and the host on a cycle-by-cycle basis, with bounded host starvation. It sits between `mem` and its two requesters: the fetcher/decoder path and the external load/debug port.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: memory address width.
- `DATA_WIDTH`, default 8: memory data width.
- `SETTLE_CYCLES`, default 2: idle cycles between boot end and core release; legal range 1–15.
- `STARVE_LIMIT`, default 4: consecutive denied host cycles before the host wins; legal range 1–15.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `host_req` in 1: host requests one memory access this cycle.
- `host_we` in 1: host access is a write.
- `host_addr` in ADDR_WIDTH: host address.
- `host_din` in DATA_WIDTH: host write data.
- `host_done` in 1: boot load complete; only meaningful in BOOT.
- `core_req` in 1: core requests one memory access this cycle.
- `core_we` in 1: core access is a write.
- `core_addr` in ADDR_WIDTH: core address.
- `core_din` in DATA_WIDTH: core write data.
- `host_grant` out 1: host access performed this cycle (combinational).
- `core_grant` out 1: core access performed this cycle (combinational).
- `host_rvalid` out 1: memory dout holds the host read data this cycle (registered).
- `core_rvalid` out 1: memory dout holds the core read data this cycle (registered).
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_WIDTH: memory address.
- `mem_din` out DATA_WIDTH: memory write data.
- `core_run` out 1: core released; the fetcher may operate (registered).

## Operation
- **States:** BOOT, SETTLE, RUN. Reset enters BOOT.
- **BOOT**
  - `host_grant = host_req`; `core_grant = 0`; `core_run = 0`.
  - `host_done = 1` moves to SETTLE. If `host_req` is also high that cycle, that access is still performed.
- **SETTLE**
  - No grants.
  - Settle counter loads `SETTLE_CYCLES-1` on entry and decrements each cycle.
  - Moves to RUN when the counter reaches 0 (exactly `SETTLE_CYCLES` cycles in SETTLE).
- **RUN**
  - `core_run = 1`.
  - Core only requesting: core granted.
  - Host only requesting: host granted.
  - Both requesting: core granted, unless `starve_cnt == STARVE_LIMIT`; then host granted.
  - `host_done` is ignored.
- **starve_cnt**
  - Increments when `host_req` is high and the host is not granted; saturates at `STARVE_LIMIT`.
  - Clears when the host is granted or `host_req` is low.
  - Held at 0 outside RUN.
- **Port mux**
  - The granted requester's `we`, `addr` and `din` drive the `mem_*` outputs.
  - With no grant: `mem_we = 0`, `mem_addr = 0`, `mem_din = 0`.
  - `mem_we` is never high without a grant.
- **rvalid**
  - `x_rvalid` is registered: high the cycle after `x_grant && !x_we`, otherwise 0.
  - At most one rvalid is high per cycle.
- Exactly one grant at most per cycle. Grants are single-cycle; a requester holding `req` high gets back-to-back accesses when it wins.

## Timing
- **Reset values** (on the edge where `reset = 1`): state BOOT, `core_run = 0`, `host_rvalid = 0`, `core_rvalid = 0`, `starve_cnt = 0`, settle counter 0.
  - While in BOOT/SETTLE, combinational outputs follow the rules above: `core_grant = 0`, and the `mem_*` outputs are idle unless a host grant is active.
- **Reset mid-RUN:** returns to BOOT on that edge. `core_run` is low the next cycle. A pending rvalid is cleared.
- **Grant latency:** 0 cycles; combinational from `req` and state in the same cycle.
- **Read data:** the memory registers on this clock, so data is valid one cycle after the grant, aligned with rvalid.
- **Boot-to-run sequence:**
  - Edge N samples `host_done`.
  - Cycles N+1 … N+SETTLE_CYCLES are in SETTLE.
  - `core_run` rises in the first RUN cycle, N+SETTLE_CYCLES+1.
- **Starvation bound:** with the core requesting continuously, a continuously requesting host is granted within `STARVE_LIMIT+1` cycles.
- **A read issued in the last BOOT cycle:** its `host_rvalid` still asserts in the first SETTLE cycle.

## Test plan
1. **Reset and idle.**
   - Stimulus: `reset` for 2 cycles, then all inputs 0.
   - Required: state BOOT, `core_run = 0`, all grants/rvalid 0, `mem_we = 0`, `mem_addr = 0`.
2. **Boot load.**
   - Stimulus: host writes 0xA9 to 0x10 and 0x04 to 0x11, then reads 0x10, with `core_req = 1` throughout.
   - Required: `core_grant` stays 0. `host_rvalid` rises one cycle after the read grant, and memory returns 0xA9.
3. **Release.**
   - Stimulus: `host_done` pulse at cycle 10 with `SETTLE_CYCLES = 2`.
   - Required: no grants in cycles 11–12; `core_run` rises in cycle 13; a core read of 0x10 then returns 0xA9.
4. **Starvation.**
   - Stimulus: in RUN, `core_req` and `host_req` both held high with `STARVE_LIMIT = 4`.
   - Required: grant pattern core ×4, host ×1, repeating. `mem_addr` follows the owner each cycle.
5. **Host-only access in RUN.**
   - Stimulus: in RUN, `core_req = 0`, host writes 0x55 to 0x02.
   - Required: immediate grant; a following read of 0x02 gives `host_rvalid` with 0x55; `starve_cnt` stays 0.
6. **Mid-run reset.**
   - Stimulus: `reset` asserted on the cycle after a core read grant.
   - Required: `core_rvalid` is 0 and `core_run` is 0 the next cycle; state BOOT; host has ownership again.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Owns the single memory port and decides, cycle by cycle, who drives it.
// After reset the host loader has the port to itself (BOOT) while the core
// is held idle. Once the host signals host_done, the port goes quiet for
// SETTLE_CYCLES cycles (SETTLE). After that the core is released (RUN) and
// the core and host share the port. The core normally wins, but the host
// is guaranteed an access after STARVE_LIMIT consecutive denied cycles.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   host_req/we/addr/din  - host (loader/debug) access request
//   host_done             - boot load complete (only acted on in BOOT)
//   core_req/we/addr/din  - core fetcher access request
//   host_grant/core_grant - access performed this cycle (combinational)
//   host_rvalid/core_rvalid - memory dout holds that requester's read data
//   mem_we/addr/din       - memory port, driven by the granted requester
//   core_run              - core released, fetcher may operate
module mem_port_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_din,
  input  logic                  host_done,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_din,
  output logic                  host_grant,
  output logic                  core_grant,
  output logic                  host_rvalid,
  output logic                  core_rvalid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  core_run
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     next_state;
  logic [3:0] settle_cnt;
  logic [3:0] settle_next;
  logic [3:0] starve_cnt;
  logic [3:0] starve_next;

  // State register. core_run is registered from the next state so it is
  // high exactly in RUN cycles without a combinational path from state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      settle_cnt  <= 4'd0;
      starve_cnt  <= 4'd0;
      core_run    <= 1'b0;
      host_rvalid <= 1'b0;
      core_rvalid <= 1'b0;
    end else begin
      state       <= next_state;
      settle_cnt  <= settle_next;
      starve_cnt  <= starve_next;
      core_run    <= (next_state == RUN);
      host_rvalid <= host_grant && !host_we;
      core_rvalid <= core_grant && !core_we;
    end
  end

  // Next-state and grant decision. The settle counter is loaded on the
  // BOOT->SETTLE transition so that SETTLE lasts exactly SETTLE_CYCLES.
  // In RUN the core has priority unless the host has been denied
  // STARVE_LIMIT cycles in a row.
  always_comb begin
    next_state  = state;
    settle_next = settle_cnt;
    host_grant  = 1'b0;
    core_grant  = 1'b0;
    case (state)
      BOOT: begin
        host_grant = host_req;
        if (host_done) begin
          next_state  = SETTLE;
          settle_next = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          next_state = RUN;
        end else begin
          settle_next = settle_cnt - 4'd1;
        end
      end
      RUN: begin
        if (host_req && core_req) begin
          if (starve_cnt == STARVE_MAX) begin
            host_grant = 1'b1;
          end else begin
            core_grant = 1'b1;
          end
        end else begin
          host_grant = host_req;
          core_grant = core_req;
        end
      end
      default: begin
        next_state = BOOT;
      end
    endcase
  end

  // Starvation counter: counts consecutive RUN cycles where the host asked
  // and lost; any other cycle (or any cycle outside RUN) clears it.
  always_comb begin
    starve_next = 4'd0;
    if ((state == RUN) && host_req && !host_grant) begin
      if (starve_cnt == STARVE_MAX) begin
        starve_next = starve_cnt;
      end else begin
        starve_next = starve_cnt + 4'd1;
      end
    end
  end

  // Port mux: the winner drives the memory; an idle port is all zeros so
  // mem_we can never be high without a grant.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (host_grant) begin
      mem_we   = host_we;
      mem_addr = host_addr;
      mem_din  = host_din;
    end else if (core_grant) begin
      mem_we   = core_we;
      mem_addr = core_addr;
      mem_din  = core_din;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Drives mem_port_arbiter with directed sequences followed by random
// traffic. A behavioural model tracks phase, consecutive host denials and
// a reference copy of memory; a small memory model is attached to the
// DUT's port. Per-cycle outputs are compared directly, and read data is
// checked by a separate monitor that pops expected results on rvalid.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SC = 2;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_req, host_we, host_done;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_din;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_din;
  logic          host_grant, core_grant, host_rvalid, core_rvalid;
  logic          mem_we, core_run;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETTLE_CYCLES(SC), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_din(host_din), .host_done(host_done),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_din(core_din),
    .host_grant(host_grant), .core_grant(core_grant),
    .host_rvalid(host_rvalid), .core_rvalid(core_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .core_run(core_run)
  );

  // Memory attached to the port: synchronous read, registered dout.
  logic          mem_clear;
  logic [DW-1:0] mem_arr [0:63];
  logic [DW-1:0] mem_dout;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= '0;
      mem_dout <= '0;
    end else begin
      if (mem_we) mem_arr[mem_addr[5:0]] <= mem_din;
      mem_dout <= mem_arr[mem_addr[5:0]];
    end
  end

  typedef struct {
    bit          is_host;
    logic [7:0]  data;
  } rd_t;

  rd_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         m_phase = 0;      // 0 boot, 1 settle, 2 run
  int         m_settle_pos = 0; // which settle cycle we are in (1..SC)
  int         m_denied = 0;     // consecutive denied host cycles in run
  bit         m_hrv = 0;
  bit         m_crv = 0;
  logic [7:0] ref_mem [0:63];

  task automatic compare(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input bit eh, input bit ec, input bit ewe,
                             input logic [15:0] eaddr, input logic [7:0] edin);
    compare("host_grant", 32'(host_grant), 32'(eh));
    compare("core_grant", 32'(core_grant), 32'(ec));
    compare("mem_we", 32'(mem_we), 32'(ewe));
    compare("mem_addr", 32'(mem_addr), 32'(eaddr));
    compare("mem_din", 32'(mem_din), 32'(edin));
    compare("core_run", 32'(core_run), 32'(m_phase == 2));
    compare("host_rvalid", 32'(host_rvalid), 32'(m_hrv));
    compare("core_rvalid", 32'(core_rvalid), 32'(m_crv));
  endtask

  // One clock cycle: drive inputs, check against the model, then advance
  // the model to what the following cycle should look like.
  task automatic applyStimulus(input bit rst, input bit hr, input bit hw,
                               input logic [5:0] ha, input logic [7:0] hd,
                               input bit done, input bit cr, input bit cw,
                               input logic [5:0] ca, input logic [7:0] cd);
    bit eh, ec, ewe;
    logic [15:0] eaddr;
    logic [7:0]  edin;
    rd_t r;
    @(negedge clk);
    reset = rst; host_req = hr; host_we = hw; host_addr = {10'd0, ha};
    host_din = hd; host_done = done; core_req = cr; core_we = cw;
    core_addr = {10'd0, ca}; core_din = cd;
    #1;
    eh = 0; ec = 0;
    if (m_phase == 0) begin
      eh = hr;
    end else if (m_phase == 2) begin
      if (hr && cr) begin
        eh = (m_denied == SL);
        ec = !eh;
      end else begin
        eh = hr;
        ec = cr;
      end
    end
    ewe = 0; eaddr = 0; edin = 0;
    if (eh) begin ewe = hw; eaddr = {10'd0, ha}; edin = hd; end
    else if (ec) begin ewe = cw; eaddr = {10'd0, ca}; edin = cd; end
    checkOutput(eh, ec, ewe, eaddr, edin);

    if (!rst && ((eh && !hw) || (ec && !cw))) begin
      r.is_host = eh;
      r.data = ref_mem[eh ? ha : ca];
      exp_q.push_back(r);
    end
    if (eh && hw) ref_mem[ha] = hd;
    if (ec && cw) ref_mem[ca] = cd;

    if (rst) begin
      m_phase = 0; m_denied = 0; m_hrv = 0; m_crv = 0; m_settle_pos = 0;
    end else begin
      m_hrv = eh && !hw;
      m_crv = ec && !cw;
      if (m_phase == 2 && hr && !eh) m_denied = (m_denied < SL) ? m_denied + 1 : SL;
      else m_denied = 0;
      if (m_phase == 0) begin
        if (done) begin m_phase = 1; m_settle_pos = 1; end
      end else if (m_phase == 1) begin
        if (m_settle_pos == SC) m_phase = 2;
        else m_settle_pos++;
      end
    end
  endtask

  task automatic idle(input int n, input bit cr);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, cr, 0, 0, 0);
  endtask

  // Read-data monitor: whenever the DUT flags read data, the oldest
  // expected read must belong to the same requester and match memory.
  initial begin
    rd_t r;
    forever begin
      @(posedge clk);
      #2;
      if (host_rvalid || core_rvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rdata_unexpected: rvalid host=%0b core=%0b with no read outstanding",
                   host_rvalid, core_rvalid);
        end else begin
          r = exp_q.pop_front();
          compare("rvalid_owner", 32'(host_rvalid), 32'(r.is_host));
          compare("rdata", 32'(mem_dout), 32'(r.data));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    mem_clear = 1; reset = 1;
    host_req = 0; host_we = 0; host_addr = 0; host_din = 0; host_done = 0;
    core_req = 0; core_we = 0; core_addr = 0; core_din = 0;

    // Reset and idle.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_clear = 0;
    idle(2, 0);

    // Boot load with the core requesting throughout.
    applyStimulus(0, 1, 1, 6'h10, 8'hA9, 0, 1, 0, 6'h20, 0);
    applyStimulus(0, 1, 1, 6'h11, 8'h04, 0, 1, 1, 6'h21, 8'hFF);
    applyStimulus(0, 1, 0, 6'h10, 8'h00, 0, 1, 0, 6'h22, 0);
    idle(3, 1);

    // Release: host_done with a read in the same cycle, then settle.
    applyStimulus(0, 1, 0, 6'h11, 8'h00, 1, 1, 0, 6'h10, 0);
    for (int i = 0; i < SC; i++) applyStimulus(0, 1, 0, 6'h11, 0, 0, 1, 0, 6'h10, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 6'h10, 0);
    idle(1, 0);

    // Starvation: both requesting continuously.
    for (int i = 0; i < 15; i++)
      applyStimulus(0, 1, 0, 6'h11, 0, 0, 1, 0, 6'(i), 0);

    // Host-only access in RUN.
    applyStimulus(0, 1, 1, 6'h02, 8'h55, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 6'h02, 8'h00, 0, 0, 0, 0, 0);
    idle(1, 0);

    // Mid-run reset after a core read grant; host owns the port again.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 6'h10, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 6'h11, 0, 0, 1, 0, 6'h12, 0);
    idle(1, 0);

    // Random traffic including occasional done pulses and resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 119) == 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                    6'($urandom), 8'($urandom),
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    6'($urandom), 8'($urandom));
    end
    idle(3, 0);

    compare("reads_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
